// File: rtl/tpu_uart_controller.sv
// -----------------------------------------------------------------------------
// tpu_uart_controller
// Host command front-end of the TPU. A UART 8N1 receiver and transmitter feed
// a command FSM that turns host bytes into weight-FIFO pushes, activation
// loads, MLP start and weight reset, and returns accumulator/status bytes.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   uart_rx / uart_tx        serial lines, both idle high
//   wf_push_col0/col1        one-cycle weight push, byte on wf_data_in
//   wf_reset                 one-cycle weight FIFO clear
//   init_act_valid/_data     one-cycle activation load with 16-bit word
//   start_mlp                one-cycle MLP start
//   weights_ready            level, set after a full WRITE_W, cleared by RESET_W
//   mlp_state/_cycle_cnt/_acc0  MLP status sampled for READ_STATUS / READ_ACC
//   dbg_*                    FSM state, command, counters and handshake taps
//
// Internal TX handshake: a byte moves when tx_valid && tx_ready are both high
// on a rising clk edge. tx_valid, once raised, stays high with a stable byte
// until accepted; tx_ready is high only while the transmitter is idle.
// -----------------------------------------------------------------------------
module tpu_uart_controller #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        wf_push_col0,
  output logic        wf_push_col1,
  output logic [7:0]  wf_data_in,
  output logic        wf_reset,
  output logic        init_act_valid,
  output logic [15:0] init_act_data,
  output logic        start_mlp,
  output logic        weights_ready,
  input  logic [3:0]  mlp_state,
  input  logic [4:0]  mlp_cycle_cnt,
  input  logic [31:0] mlp_acc0,
  output logic [3:0]  dbg_state,
  output logic [7:0]  dbg_cmd_reg,
  output logic [2:0]  dbg_byte_count,
  output logic [1:0]  dbg_resp_byte_idx,
  output logic        dbg_tx_valid,
  output logic        dbg_tx_ready,
  output logic        dbg_rx_valid,
  output logic        dbg_weights_ready,
  output logic        dbg_start_mlp
);

  localparam int          BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_TICKS - 1);
  localparam logic [15:0] HALF_LAST = 16'(BIT_TICKS / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_BITS  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_RX_DATA = 4'd1;
  localparam logic [3:0] ST_EXEC    = 4'd2;
  localparam logic [3:0] ST_TX_SEND = 4'd3;
  localparam logic [3:0] ST_TX_WAIT = 4'd4;

  localparam logic [7:0] CMD_WRITE_W     = 8'h01;
  localparam logic [7:0] CMD_WRITE_ACT   = 8'h02;
  localparam logic [7:0] CMD_EXECUTE     = 8'h03;
  localparam logic [7:0] CMD_READ_ACC    = 8'h04;
  localparam logic [7:0] CMD_READ_STATUS = 8'h05;
  localparam logic [7:0] CMD_RESET_W     = 8'h06;

  // ---------------------------------------------------------------- UART RX
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]  rx_st_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_valid_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= '0;
          end
        end
        RX_START: begin
          // Half a bit in: a line already back high was a glitch.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_sync_q ? RX_IDLE : RX_BITS;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_BITS: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
            else                  rx_bit_q <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: begin
          // Stop bit: a low sample is a framing error and the byte is dropped.
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_st_q    <= RX_IDLE;
            rx_valid_q <= rx_sync_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- UART TX
  logic [3:0]  state_q;
  logic [1:0]  idx_q;
  logic [31:0] resp_q;
  logic [9:0]  tx_shift_q;
  logic        tx_busy_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_byte;

  assign tx_valid = (state_q == ST_TX_SEND);
  assign tx_ready = !tx_busy_q;

  always_comb begin
    tx_byte = resp_q[7:0];
    case (idx_q)
      2'd1:    tx_byte = resp_q[15:8];
      2'd2:    tx_byte = resp_q[23:16];
      2'd3:    tx_byte = resp_q[31:24];
      default: tx_byte = resp_q[7:0];
    endcase
  end

  // The frame shifts out of bit 0; refilling with ones keeps the idle line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_q <= '1;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else if (!tx_busy_q) begin
      if (tx_valid) begin
        tx_shift_q <= {1'b1, tx_byte, 1'b0};
        tx_busy_q  <= 1'b1;
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
      end
    end else if (tx_cnt_q == BIT_LAST) begin
      tx_cnt_q   <= '0;
      tx_shift_q <= {1'b1, tx_shift_q[9:1]};
      if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
        tx_bit_q  <= '0;
      end else begin
        tx_bit_q <= tx_bit_q + 4'd1;
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  assign uart_tx = tx_shift_q[0];

  // ------------------------------------------------------------ Command FSM
  logic [7:0]  cmd_q, wf_data_q, act_lo_q;
  logic [2:0]  byte_cnt_q;
  logic [1:0]  last_idx_q;
  logic [15:0] act_data_q;
  logic        push0_q, push1_q, wf_reset_q, act_valid_q, start_q, wready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      byte_cnt_q  <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      resp_q      <= '0;
      act_lo_q    <= '0;
      act_data_q  <= '0;
      wf_data_q   <= '0;
      push0_q     <= 1'b0;
      push1_q     <= 1'b0;
      wf_reset_q  <= 1'b0;
      act_valid_q <= 1'b0;
      start_q     <= 1'b0;
      wready_q    <= 1'b0;
    end else begin
      push0_q     <= 1'b0;
      push1_q     <= 1'b0;
      wf_reset_q  <= 1'b0;
      act_valid_q <= 1'b0;
      start_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid_q) begin
            cmd_q      <= rx_shift_q;
            byte_cnt_q <= '0;
            case (rx_shift_q)
              CMD_WRITE_W, CMD_WRITE_ACT: state_q <= ST_RX_DATA;
              CMD_EXECUTE: state_q <= ST_EXEC;
              CMD_READ_ACC: begin
                resp_q     <= mlp_acc0;
                last_idx_q <= 2'd3;
                idx_q      <= '0;
                state_q    <= ST_TX_SEND;
              end
              CMD_READ_STATUS: begin
                resp_q     <= {16'h0, 3'b0, mlp_cycle_cnt, 4'b0, mlp_state};
                last_idx_q <= 2'd1;
                idx_q      <= '0;
                state_q    <= ST_TX_SEND;
              end
              CMD_RESET_W: begin
                wf_reset_q <= 1'b1;
                wready_q   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_RX_DATA: begin
          if (rx_valid_q) begin
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (cmd_q == CMD_WRITE_W) begin
              // Payload bytes 0,1 go to column 0; bytes 2,3 to column 1.
              wf_data_q <= rx_shift_q;
              if (byte_cnt_q[1]) push1_q <= 1'b1;
              else               push0_q <= 1'b1;
              if (byte_cnt_q == 3'd3) begin
                wready_q <= 1'b1;
                state_q  <= ST_IDLE;
              end
            end else if (byte_cnt_q == 3'd0) begin
              act_lo_q <= rx_shift_q;
            end else begin
              act_data_q  <= {rx_shift_q, act_lo_q};
              act_valid_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_EXEC: begin
          start_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_TX_SEND: begin
          if (tx_ready) state_q <= ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (tx_ready) begin
            if (idx_q == last_idx_q) begin
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= ST_TX_SEND;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wf_push_col0      = push0_q;
  assign wf_push_col1      = push1_q;
  assign wf_data_in        = wf_data_q;
  assign wf_reset          = wf_reset_q;
  assign init_act_valid    = act_valid_q;
  assign init_act_data     = act_data_q;
  assign start_mlp         = start_q;
  assign weights_ready     = wready_q;
  assign dbg_state         = state_q;
  assign dbg_cmd_reg       = cmd_q;
  assign dbg_byte_count    = byte_cnt_q;
  assign dbg_resp_byte_idx = idx_q;
  assign dbg_tx_valid      = tx_valid;
  assign dbg_tx_ready      = tx_ready;
  assign dbg_rx_valid      = rx_valid_q;
  assign dbg_weights_ready = wready_q;
  assign dbg_start_mlp     = start_q;

endmodule

// File: tb/tb_tpu_uart_controller.sv
// -----------------------------------------------------------------------------
// tb_tpu_uart_controller
// Directed bench for tpu_uart_controller at 10 clocks per UART bit. Host bytes
// are driven onto uart_rx, strobes are logged by a negedge monitor, and
// response frames on uart_tx are decoded and compared with exp_q.
// -----------------------------------------------------------------------------
module tb_tpu_uart_controller;
  localparam int BT = 10;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        uart_rx, uart_tx;
  logic        wf_push_col0, wf_push_col1, wf_reset, init_act_valid, start_mlp;
  logic        weights_ready;
  logic [7:0]  wf_data_in;
  logic [15:0] init_act_data;
  logic [3:0]  mlp_state;
  logic [4:0]  mlp_cycle_cnt;
  logic [31:0] mlp_acc0;
  logic [3:0]  dbg_state;
  logic [7:0]  dbg_cmd_reg;
  logic [2:0]  dbg_byte_count;
  logic [1:0]  dbg_resp_byte_idx;
  logic        dbg_tx_valid, dbg_tx_ready, dbg_rx_valid;
  logic        dbg_weights_ready, dbg_start_mlp;

  tpu_uart_controller #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .wf_push_col0(wf_push_col0), .wf_push_col1(wf_push_col1),
    .wf_data_in(wf_data_in), .wf_reset(wf_reset),
    .init_act_valid(init_act_valid), .init_act_data(init_act_data),
    .start_mlp(start_mlp), .weights_ready(weights_ready),
    .mlp_state(mlp_state), .mlp_cycle_cnt(mlp_cycle_cnt), .mlp_acc0(mlp_acc0),
    .dbg_state(dbg_state), .dbg_cmd_reg(dbg_cmd_reg),
    .dbg_byte_count(dbg_byte_count), .dbg_resp_byte_idx(dbg_resp_byte_idx),
    .dbg_tx_valid(dbg_tx_valid), .dbg_tx_ready(dbg_tx_ready),
    .dbg_rx_valid(dbg_rx_valid), .dbg_weights_ready(dbg_weights_ready),
    .dbg_start_mlp(dbg_start_mlp)
  );

  // ------------------------------------------------------ scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_got_q[$];
  logic [7:0] col0_q[$];
  logic [7:0] col1_q[$];
  logic [1:0] idx_q[$];
  int wfr_cnt = 0, act_cnt = 0, start_cnt = 0, rxv_cnt = 0;
  int multi_cnt = 0, dbg_mis = 0, tx_frame_err = 0;
  logic [15:0] act_last = '0;
  logic [7:0]  mon_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qget(input logic [7:0] q[$], input int i);
    if (q.size() > i) return q[i];
    return 8'hxx;
  endfunction

  // Strobe / handshake monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (wf_push_col0) col0_q.push_back(wf_data_in);
    if (wf_push_col1) col1_q.push_back(wf_data_in);
    if (wf_reset) wfr_cnt++;
    if (init_act_valid) begin act_cnt++; act_last = init_act_data; end
    if (start_mlp) start_cnt++;
    if (dbg_rx_valid) rxv_cnt++;
    if (dbg_tx_valid && dbg_tx_ready) idx_q.push_back(dbg_resp_byte_idx);
    if ((int'(wf_push_col0) + int'(wf_push_col1) + int'(wf_reset)
         + int'(init_act_valid) + int'(start_mlp)) > 1) multi_cnt++;
    if (dbg_start_mlp !== start_mlp || dbg_weights_ready !== weights_ready) dbg_mis++;
  end

  // uart_tx frame decoder: samples each bit mid-way through its 10 clocks.
  always begin
    @(negedge uart_tx);
    repeat (BT / 2) @(posedge clk);
    #1;
    if (uart_tx !== 1'b0) tx_frame_err++;
    for (int i = 0; i < 8; i++) begin
      repeat (BT) @(posedge clk);
      #1;
      mon_b[i] = uart_tx;
    end
    repeat (BT) @(posedge clk);
    #1;
    if (uart_tx !== 1'b1) tx_frame_err++;
    tx_got_q.push_back(mon_b);
  end

  // ------------------------------------------------------ driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 uart_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BT) @(posedge clk); #1 uart_rx = b[i];
    end
    repeat (BT) @(posedge clk); #1 uart_rx = stop_bit;
    repeat (BT) @(posedge clk); #1 uart_rx = 1'b1;
    repeat (2 * BT) @(posedge clk);
  endtask

  task automatic wait_response(input int n);
    int k;
    k = 0;
    while (tx_got_q.size() < n && k < 2000) begin @(posedge clk); k++; end
    k = 0;
    while (dbg_state != 4'd0 && k < 200) begin @(posedge clk); k++; end
    @(negedge clk);
    check("resp_byte_count", 32'(tx_got_q.size()), 32'(n));
    check("resp_state_idle", 32'(dbg_state), 32'd0);
    for (int i = 0; i < n; i++) begin
      check("resp_byte", 32'(qget(tx_got_q, i)), 32'(exp_q[i]));
      check("resp_idx", 32'(idx_q.size() > i ? idx_q[i] : 2'bxx), 32'(i));
    end
    exp_q.delete();
    tx_got_q.delete();
    idx_q.delete();
  endtask

  // ------------------------------------------------------ directed sequence
  int snap_a, snap_b;

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    mlp_state = 4'd5;
    mlp_cycle_cnt = 5'd17;
    mlp_acc0 = 32'hDEADBEEF;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_cmd", 32'(dbg_cmd_reg), 32'd0);
    check("rst_byte_cnt", 32'(dbg_byte_count), 32'd0);
    check("rst_idx", 32'(dbg_resp_byte_idx), 32'd0);
    check("rst_strobes", 32'({wf_push_col0, wf_push_col1, wf_reset, init_act_valid, start_mlp}), 32'd0);
    check("rst_wf_data", 32'(wf_data_in), 32'd0);
    check("rst_act_data", 32'(init_act_data), 32'd0);
    check("rst_wready", 32'(weights_ready), 32'd0);
    check("rst_tx_ready", 32'(dbg_tx_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // WRITE_W 0x11 0x22 0x33 0x44
    send_byte(8'h01, 1'b1);
    check("ww_state_rx_data", 32'(dbg_state), 32'd1);
    check("ww_cmd", 32'(dbg_cmd_reg), 32'h01);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("ww_byte_cnt_2", 32'(dbg_byte_count), 32'd2);
    check("ww_wready_mid", 32'(weights_ready), 32'd0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("ww_col0_n", 32'(col0_q.size()), 32'd2);
    check("ww_col0_0", 32'(qget(col0_q, 0)), 32'h11);
    check("ww_col0_1", 32'(qget(col0_q, 1)), 32'h22);
    check("ww_col1_n", 32'(col1_q.size()), 32'd2);
    check("ww_col1_0", 32'(qget(col1_q, 0)), 32'h33);
    check("ww_col1_1", 32'(qget(col1_q, 1)), 32'h44);
    check("ww_wready", 32'(weights_ready), 32'd1);
    check("ww_state_idle", 32'(dbg_state), 32'd0);

    // WRITE_ACT 0x34 0x12 -> 0x1234
    send_byte(8'h02, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    check("act_pulses", 32'(act_cnt), 32'd1);
    check("act_data_pulse", 32'(act_last), 32'h1234);
    check("act_state_idle", 32'(dbg_state), 32'd0);

    // EXECUTE
    send_byte(8'h03, 1'b1);
    check("exec_start_cycles", 32'(start_cnt), 32'd1);
    check("exec_state_idle", 32'(dbg_state), 32'd0);

    // READ_ACC, little-endian
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    send_byte(8'h04, 1'b1);
    wait_response(4);

    // READ_STATUS
    exp_q.push_back(8'h05); exp_q.push_back(8'h11);
    send_byte(8'h05, 1'b1);
    wait_response(2);

    // Reset in the middle of WRITE_W, then a full WRITE_W
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check("mid_wf_data", 32'(wf_data_in), 32'hBB);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_cmd", 32'(dbg_cmd_reg), 32'd0);
    check("mid_rst_byte_cnt", 32'(dbg_byte_count), 32'd0);
    check("mid_rst_wready", 32'(weights_ready), 32'd0);
    check("mid_rst_wf_data", 32'(wf_data_in), 32'd0);
    check("mid_rst_act_data", 32'(init_act_data), 32'd0);
    check("mid_rst_uart_tx", 32'(uart_tx), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    col0_q.delete();
    col1_q.delete();
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    check("ww2_col0_n", 32'(col0_q.size()), 32'd2);
    check("ww2_col0_0", 32'(qget(col0_q, 0)), 32'h55);
    check("ww2_col0_1", 32'(qget(col0_q, 1)), 32'h66);
    check("ww2_col1_n", 32'(col1_q.size()), 32'd2);
    check("ww2_col1_0", 32'(qget(col1_q, 0)), 32'h77);
    check("ww2_col1_1", 32'(qget(col1_q, 1)), 32'h88);
    check("ww2_wready", 32'(weights_ready), 32'd1);

    // RESET_W
    send_byte(8'h06, 1'b1);
    check("rw_pulses", 32'(wfr_cnt), 32'd1);
    check("rw_wready", 32'(weights_ready), 32'd0);
    check("rw_state", 32'(dbg_state), 32'd0);

    // Unknown command
    snap_a = col0_q.size() + col1_q.size() + wfr_cnt + act_cnt + start_cnt;
    send_byte(8'h7F, 1'b1);
    check("unk_strobes", 32'(col0_q.size() + col1_q.size() + wfr_cnt + act_cnt + start_cnt), 32'(snap_a));
    check("unk_state", 32'(dbg_state), 32'd0);
    check("unk_cmd", 32'(dbg_cmd_reg), 32'h7F);

    // Framing error: EXECUTE with stop bit 0 must be discarded
    snap_a = rxv_cnt;
    snap_b = start_cnt;
    send_byte(8'h03, 1'b0);
    check("frm_rx_valid", 32'(rxv_cnt), 32'(snap_a));
    check("frm_start", 32'(start_cnt), 32'(snap_b));
    check("frm_state", 32'(dbg_state), 32'd0);

    // Two-clock glitch on uart_rx must not start a frame
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (2) @(posedge clk); #1 uart_rx = 1'b1;
    repeat (20 * BT) @(posedge clk);
    check("glitch_rx_valid", 32'(rxv_cnt), 32'(snap_a));
    send_byte(8'h03, 1'b1);
    check("post_glitch_start", 32'(start_cnt), 32'(snap_b + 1));

    @(negedge clk);
    check("one_hot_strobes", 32'(multi_cnt), 32'd0);
    check("dbg_copies", 32'(dbg_mis), 32'd0);
    check("tx_frame_bits", 32'(tx_frame_err), 32'd0);
    check("final_uart_tx", 32'(uart_tx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
